// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared types and default lengths for the CAN transmit bit engine
package can_pkg;

  localparam int              DEF_STUFF_LEN     = 5;
  localparam int              DEF_CRC_WIDTH     = 15;
  localparam int              DEF_ERR_FLAG_LEN  = 6;
  localparam int              DEF_ERR_DELIM_LEN = 8;
  localparam logic [14:0]     CAN_CRC_POLY      = 15'h4599;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STUFF,
    ST_CRC,
    ST_ERR_FLAG,
    ST_ERR_DELIM
  } tx_state_t;

endpackage

// File: rtl/can_crc15.sv
// rtl/can_crc15.sv - serial MSB-first CAN CRC LFSR; clr and en may coincide (SOF clears then absorbs)
module can_crc15
  import can_pkg::*;
#(
  parameter int               WIDTH = DEF_CRC_WIDTH,
  parameter logic [WIDTH-1:0] POLY  = CAN_CRC_POLY
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             d,
  output logic [WIDTH-1:0] crc
);

  logic [WIDTH-1:0] crc_q, crc_d, base;
  logic             fb;

  always_comb begin
    base  = clr ? '0 : crc_q;
    fb    = d ^ base[WIDTH-1];
    crc_d = base;
    if (en) begin
      crc_d = {base[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/can_tx_bit_stuffer.sv
// rtl/can_tx_bit_stuffer.sv - CAN TX bit engine: stuffing, CRC append, readback checks
// Error flag/delimiter generation is built only when CAN_ERR_FRAME_EN is defined.
module can_tx_bit_stuffer
  import can_pkg::*;
#(
  parameter int                   STUFF_LEN = DEF_STUFF_LEN,
  parameter int                   CRC_WIDTH = DEF_CRC_WIDTH,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = CAN_CRC_POLY
`ifdef CAN_ERR_FRAME_EN
  ,
  parameter int                   ERR_FLAG_LEN  = DEF_ERR_FLAG_LEN,
  parameter int                   ERR_DELIM_LEN = DEF_ERR_DELIM_LEN
`endif
) (
  input  logic clock,
  input  logic reset,
  input  logic SP,
  input  logic RX,
  input  logic in_valid,
  input  logic in_bit,
  input  logic in_stuff,
  input  logic in_arb,
  input  logic in_crc,
  output logic in_ready,
  output logic TX,
  output logic STF_INS,
  output logic ARB_LOST,
  output logic BIT_ERR,
  output logic busy
);

  localparam int CW = $clog2(STUFF_LEN + 1);
  localparam int IW = $clog2(CRC_WIDTH);

  tx_state_t      state_q, state_d;
  logic           tx_q, tx_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           crc_pend_q, crc_pend_d;
  logic [IW-1:0]  crc_idx_q, crc_idx_d;
  logic [1:0]     post_crc_q, post_crc_d;
  logic           cur_stuff_q, cur_stuff_d;
  logic           cur_arb_q, cur_arb_d;
  logic           cur_ack_q, cur_ack_d;
  logic           arb_lost_q, arb_lost_d;
  logic           bit_err_q, bit_err_d;
`ifdef CAN_ERR_FRAME_EN
  localparam int EW = $clog2(((ERR_FLAG_LEN > ERR_DELIM_LEN) ? ERR_FLAG_LEN : ERR_DELIM_LEN) + 1);
  logic [EW-1:0]  err_cnt_q, err_cnt_d;
`endif

  logic                 crc_clr, crc_en;
  logic [CRC_WIDTH-1:0] crc;
  logic                 on_bus, lost, mism, ctx_clr;

  can_crc15 #(.WIDTH(CRC_WIDTH), .POLY(CRC_POLY)) u_crc (
    .clock (clock),
    .reset (reset),
    .clr   (crc_clr),
    .en    (crc_en),
    .d     (in_bit),
    .crc   (crc)
  );

  // Run length of identical bits; a zero count means the previous bit was outside the stuffed region.
  function automatic logic [CW-1:0] bump(input logic b, input logic prev, input logic [CW-1:0] c);
    return (c != '0 && b == prev) ? c + CW'(1) : CW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    tx_d        = tx_q;
    cnt_d       = cnt_q;
    crc_pend_d  = crc_pend_q;
    crc_idx_d   = crc_idx_q;
    post_crc_d  = post_crc_q;
    cur_stuff_d = cur_stuff_q;
    cur_arb_d   = cur_arb_q;
    cur_ack_d   = cur_ack_q;
    arb_lost_d  = 1'b0;
    bit_err_d   = 1'b0;
    in_ready    = 1'b0;
    crc_clr     = 1'b0;
    crc_en      = 1'b0;
    ctx_clr     = 1'b0;
`ifdef CAN_ERR_FRAME_EN
    err_cnt_d   = err_cnt_q;
`endif

    on_bus = (state_q == ST_DATA) || (state_q == ST_STUFF) || (state_q == ST_CRC);
    lost   = on_bus && cur_arb_q && tx_q && !RX;
    mism   = on_bus && (tx_q != RX) && !(cur_ack_q && tx_q && !RX);

    if (SP && reset) begin
      case (state_q)
`ifdef CAN_ERR_FRAME_EN
        ST_ERR_FLAG: begin
          if (err_cnt_q == EW'(ERR_FLAG_LEN)) begin
            state_d   = ST_ERR_DELIM;
            tx_d      = 1'b1;
            err_cnt_d = EW'(1);
          end else begin
            err_cnt_d = err_cnt_q + EW'(1);
          end
        end
        ST_ERR_DELIM: begin
          if (err_cnt_q == EW'(ERR_DELIM_LEN)) begin
            state_d   = ST_IDLE;
            err_cnt_d = '0;
          end else begin
            err_cnt_d = err_cnt_q + EW'(1);
          end
        end
`endif
        default: begin
          if (lost) begin
            arb_lost_d = 1'b1;
            state_d    = ST_IDLE;
            tx_d       = 1'b1;
            ctx_clr    = 1'b1;
          end else if (mism) begin
            bit_err_d = 1'b1;
            ctx_clr   = 1'b1;
`ifdef CAN_ERR_FRAME_EN
            state_d   = ST_ERR_FLAG;
            tx_d      = 1'b0;
            err_cnt_d = EW'(1);
`else
            state_d   = ST_IDLE;
            tx_d      = 1'b1;
`endif
          end else if (on_bus && cur_stuff_q && cnt_q == CW'(STUFF_LEN)) begin
            state_d   = ST_STUFF;
            tx_d      = ~tx_q;
            cnt_d     = CW'(1);
            cur_arb_d = 1'b0;
            cur_ack_d = 1'b0;
          end else if (crc_pend_q) begin
            state_d     = ST_CRC;
            tx_d        = crc[crc_idx_q];
            cnt_d       = bump(crc[crc_idx_q], tx_q, cnt_q);
            cur_stuff_d = 1'b1;
            cur_arb_d   = 1'b0;
            cur_ack_d   = 1'b0;
            if (crc_idx_q == '0) begin
              crc_pend_d = 1'b0;
              post_crc_d = 2'd1;
            end else begin
              crc_idx_d = crc_idx_q - IW'(1);
            end
          end else if (in_valid) begin
            in_ready    = 1'b1;
            state_d     = ST_DATA;
            tx_d        = in_bit;
            cur_stuff_d = in_stuff;
            cur_arb_d   = in_arb;
            cur_ack_d   = (post_crc_q == 2'd2) && !in_stuff && !in_arb && !in_crc;
            post_crc_d  = (post_crc_q == 2'd1) ? 2'd2 : 2'd0;
            crc_clr     = (state_q == ST_IDLE);
            crc_en      = in_stuff;
            cnt_d       = in_stuff ? bump(in_bit, tx_q, cnt_q) : '0;
            if (in_crc) begin
              crc_pend_d = 1'b1;
              crc_idx_d  = IW'(CRC_WIDTH - 1);
            end
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
            ctx_clr = 1'b1;
          end
        end
      endcase
    end

    if (ctx_clr) begin
      cnt_d       = '0;
      crc_pend_d  = 1'b0;
      crc_idx_d   = '0;
      post_crc_d  = 2'd0;
      cur_stuff_d = 1'b0;
      cur_arb_d   = 1'b0;
      cur_ack_d   = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      tx_q        <= 1'b1;
      cnt_q       <= '0;
      crc_pend_q  <= 1'b0;
      crc_idx_q   <= '0;
      post_crc_q  <= 2'd0;
      cur_stuff_q <= 1'b0;
      cur_arb_q   <= 1'b0;
      cur_ack_q   <= 1'b0;
      arb_lost_q  <= 1'b0;
      bit_err_q   <= 1'b0;
`ifdef CAN_ERR_FRAME_EN
      err_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      tx_q        <= tx_d;
      cnt_q       <= cnt_d;
      crc_pend_q  <= crc_pend_d;
      crc_idx_q   <= crc_idx_d;
      post_crc_q  <= post_crc_d;
      cur_stuff_q <= cur_stuff_d;
      cur_arb_q   <= cur_arb_d;
      cur_ack_q   <= cur_ack_d;
      arb_lost_q  <= arb_lost_d;
      bit_err_q   <= bit_err_d;
`ifdef CAN_ERR_FRAME_EN
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign TX       = tx_q;
  assign STF_INS  = (state_q == ST_STUFF);
  assign ARB_LOST = arb_lost_q;
  assign BIT_ERR  = bit_err_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// tb/tb_can_tx_bit_stuffer.sv - scoreboard bench for the CAN TX bit engine
module tb_can_tx_bit_stuffer;

  logic clock = 1'b0;
  logic reset, SP, RX, in_valid, in_bit, in_stuff, in_arb, in_crc;
  logic in_ready, TX, STF_INS, ARB_LOST, BIT_ERR, busy;
  logic rx_ovr_en, rx_ovr_val, cur_rxdom;

  always #5 clock = ~clock;

  assign RX = rx_ovr_en ? rx_ovr_val : (cur_rxdom ? 1'b0 : TX);

  can_tx_bit_stuffer dut (
    .clock    (clock),
    .reset    (reset),
    .SP       (SP),
    .RX       (RX),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .in_stuff (in_stuff),
    .in_arb   (in_arb),
    .in_crc   (in_crc),
    .in_ready (in_ready),
    .TX       (TX),
    .STF_INS  (STF_INS),
    .ARB_LOST (ARB_LOST),
    .BIT_ERR  (BIT_ERR),
    .busy     (busy)
  );

  typedef struct packed {logic b; logic stf; logic arb; logic crc; logic rxdom;} fbit_t;
  typedef struct packed {logic tx; logic stf; logic rdy; logic rxdom;} exp_t;

  fbit_t       frame_q[$];
  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic        m_prev;
  int          m_cnt;
  logic [14:0] m_crc;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic b, input logic s, input logic a, input logic c);
    in_valid = v; in_bit = b; in_stuff = s; in_arb = a; in_crc = c;
  endtask

  task automatic sp_tick(output logic rdy);
    repeat (2) @(negedge clock);
    SP = 1'b1;
    #4;
    rdy = in_ready;
    @(posedge clock);
    #1;
    SP = 1'b0;
  endtask

  task automatic fpush(input logic b, input logic s, input logic a, input logic c, input logic rxd);
    frame_q.push_back({b, s, a, c, rxd});
  endtask

  task automatic m_emit(input logic b, input logic stuffed, input logic rdy, input logic rxd);
    if (stuffed) m_cnt = (m_cnt > 0 && b == m_prev) ? m_cnt + 1 : 1;
    else         m_cnt = 0;
    m_prev = b;
    exp_q.push_back({b, 1'b0, rdy, rxd});
    if (stuffed && m_cnt == 5) begin
      m_prev = ~b;
      m_cnt  = 1;
      exp_q.push_back({~b, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic build_expected();
    logic nxt;
    exp_q.delete();
    m_cnt = 0; m_prev = 1'b1; m_crc = '0;
    foreach (frame_q[i]) begin
      if (frame_q[i].stf) begin
        nxt   = frame_q[i].b ^ m_crc[14];
        m_crc = {m_crc[13:0], 1'b0};
        if (nxt) m_crc = m_crc ^ 15'h4599;
      end
      m_emit(frame_q[i].b, frame_q[i].stf, 1'b1, frame_q[i].rxdom);
      if (frame_q[i].crc)
        for (int k = 14; k >= 0; k--) m_emit(m_crc[k], 1'b1, 1'b0, 1'b0);
    end
  endtask

  task automatic run_frame(input string nm);
    int    idx, guard;
    exp_t  e;
    logic  rdy;
    build_expected();
    idx = 0; guard = 0;
    while (exp_q.size() > 0 && guard < 400) begin
      if (idx < frame_q.size())
        drive(1'b1, frame_q[idx].b, frame_q[idx].stf, frame_q[idx].arb, frame_q[idx].crc);
      else
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      sp_tick(rdy);
      e = exp_q.pop_front();
      check_eq({nm, "_tx"}, TX, e.tx);
      check_eq({nm, "_stf_ins"}, STF_INS, e.stf);
      check_eq({nm, "_in_ready"}, rdy, e.rdy);
      check_eq({nm, "_arb_lost"}, ARB_LOST, 0);
      check_eq({nm, "_bit_err"}, BIT_ERR, 0);
      check_eq({nm, "_busy"}, busy, 1);
      if (rdy) idx++;
      cur_rxdom = e.rxdom;
      guard++;
    end
    check_eq({nm, "_drain"}, exp_q.size(), 0);
    check_eq({nm, "_consumed"}, idx, frame_q.size());
    cur_rxdom = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sp_tick(rdy);
    check_eq({nm, "_end_tx"}, TX, 1);
    check_eq({nm, "_end_busy"}, busy, 0);
    check_eq({nm, "_end_rdy"}, rdy, 0);
  endtask

  task automatic build_id123();
    logic [10:0] id;
    id = 11'h123;
    frame_q.delete();
    fpush(0, 1, 0, 0, 0);
    for (int i = 10; i >= 0; i--) fpush(id[i], 1, 1, 0, 0);
    fpush(0, 1, 1, 0, 0);
    fpush(0, 1, 0, 0, 0);
    fpush(0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) fpush(0, 1, 0, 0, 0);
    fpush(0, 1, 0, 1, 0);
    fpush(1, 0, 0, 0, 0);
    fpush(1, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) fpush(1, 0, 0, 0, 0);
  endtask

  initial begin
    logic rdy;
    reset = 1'b0; SP = 1'b0; rx_ovr_en = 1'b0; rx_ovr_val = 1'b1; cur_rxdom = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    SP = 1'b1;
    #1;
    check_eq("rst_tx", TX, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_stf_ins", STF_INS, 0);
    check_eq("rst_arb_lost", ARB_LOST, 0);
    check_eq("rst_bit_err", BIT_ERR, 0);
    SP = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    frame_q.delete();
    fpush(0, 1, 0, 0, 0); for (int i = 0; i < 4; i++) fpush(0, 1, 0, 0, 0); fpush(1, 1, 0, 0, 0);
    run_frame("zeros_stuff");

    frame_q.delete();
    fpush(0, 1, 0, 0, 0); for (int i = 0; i < 5; i++) fpush(1, 1, 0, 0, 0); fpush(0, 1, 0, 0, 0);
    run_frame("ones_stuff");

    build_id123();
    run_frame("id123_crc");

    // Arbitration loss on a recessive ID bit
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sp_tick(rdy);
    check_eq("arb_sof_tx", TX, 0);
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    sp_tick(rdy);
    check_eq("arb_bit_tx", TX, 1);
    check_eq("arb_bit_rdy", rdy, 1);
    rx_ovr_en = 1'b1; rx_ovr_val = 1'b0;
    sp_tick(rdy);
    check_eq("arb_lost_rdy", rdy, 0);
    check_eq("arb_lost_pulse", ARB_LOST, 1);
    check_eq("arb_lost_no_berr", BIT_ERR, 0);
    check_eq("arb_lost_tx", TX, 1);
    check_eq("arb_lost_busy", busy, 0);
    @(posedge clock); #1;
    check_eq("arb_lost_width", ARB_LOST, 0);
    rx_ovr_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Bit error on a dominant data bit read back recessive
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sp_tick(rdy);
    check_eq("berr_sof_tx", TX, 0);
    rx_ovr_en = 1'b1; rx_ovr_val = 1'b1;
    sp_tick(rdy);
    check_eq("berr_rdy", rdy, 0);
    check_eq("berr_pulse", BIT_ERR, 1);
    check_eq("berr_no_arb", ARB_LOST, 0);
`ifdef CAN_ERR_FRAME_EN
    check_eq("eflag_first_tx", TX, 0);
    check_eq("eflag_first_busy", busy, 1);
    for (int i = 1; i < 14; i++) begin
      sp_tick(rdy);
      check_eq($sformatf("eframe%0d_tx", i), TX, (i < 6) ? 0 : 1);
      check_eq($sformatf("eframe%0d_busy", i), busy, 1);
      check_eq($sformatf("eframe%0d_rdy", i), rdy, 0);
      check_eq($sformatf("eframe%0d_berr", i), BIT_ERR, 0);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sp_tick(rdy);
    check_eq("eframe_end_busy", busy, 0);
    check_eq("eframe_end_tx", TX, 1);
`else
    check_eq("berr_tx", TX, 1);
    check_eq("berr_busy", busy, 0);
    @(posedge clock); #1;
    check_eq("berr_width", BIT_ERR, 0);
`endif
    rx_ovr_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset asserted while CRC bits are going out
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    sp_tick(rdy);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    sp_tick(rdy);
    check_eq("mid_crc_last_rdy", rdy, 1);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    sp_tick(rdy);
    check_eq("mid_crc_rdy", rdy, 0);
    check_eq("mid_crc_busy", busy, 1);
    @(negedge clock); #2;
    reset = 1'b0;
    SP    = 1'b1;
    #1;
    check_eq("mrst_tx", TX, 1);
    check_eq("mrst_busy", busy, 0);
    check_eq("mrst_stf_ins", STF_INS, 0);
    check_eq("mrst_arb_lost", ARB_LOST, 0);
    check_eq("mrst_bit_err", BIT_ERR, 0);
    check_eq("mrst_in_ready", in_ready, 0);
    @(posedge clock); #1;
    check_eq("mrst_sp_ignored_busy", busy, 0);
    SP = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sp_tick(rdy);
    check_eq("post_rst_tx", TX, 1);
    check_eq("post_rst_busy", busy, 0);

    build_id123();
    run_frame("id123_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
